// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the lw/sw/R-type/beq subset of RV32I.
// The state register and the 8-bit wait counter are the only flops. Every
// control output is a combinational decode of the current state, plus Zero
// and mem_ready where the datapath needs them in the same cycle.
//
// Memory handshake: mem_req (with MemWrite/AdrSrc) is held steady while the
// FSM sits in FETCH, MEMRD or MEMWR. The access completes in the cycle where
// mem_req and mem_ready are both high. If mem_ready has not arrived by the
// TIMEOUT_CYCLES-th cycle in one of those states, the FSM traps into FAULT.
// mem_ready is ignored in every other state.
//
// The fault cause is held by splitting FAULT into two encodings, so no extra
// flop is needed. state_dbg exposes the raw state encoding for checkers.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUsrcA,
    output logic [1:0]  ALUsrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUctrl,
    output logic [1:0]  ResultSrc,
    output logic        instr_done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        START     = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEMADR    = 4'd3,
        MEMRD     = 4'd4,
        MEMWB     = 4'd5,
        MEMWR     = 4'd6,
        EXECR     = 4'd7,
        ALUWB     = 4'd8,
        BEQ       = 4'd9,
        FAULT_ILL = 4'd10,
        FAULT_TMO = 4'd11
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        waiting;
    logic        timeout;
    logic        rtype_ok;
    logic        unused_instr;

    assign op           = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign funct7       = Instr[31:25];
    assign unused_instr = ^{Instr[24:15], Instr[11:7]};
    assign state_dbg    = state;

    // Memory-wait states and the cycle in which a missing mem_ready traps.
    assign waiting = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    assign timeout = waiting && !mem_ready && (wait_cnt == TMO_LAST);

    // Legal R-type: add/sub/slt/or/and; funct7=0100000 only for sub.
    always_comb begin
        rtype_ok = 1'b0;
        if (funct3 == 3'b000 || funct3 == 3'b010 ||
            funct3 == 3'b110 || funct3 == 3'b111) begin
            rtype_ok = (funct7 == 7'b0000000) ||
                       (funct7 == 7'b0100000 && funct3 == 3'b000);
        end
    end

    // Next-state selection; mem_ready wins over the timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            START:  state_next = FETCH;
            FETCH: begin
                if (mem_ready)    state_next = DECODE;
                else if (timeout) state_next = FAULT_TMO;
            end
            DECODE: begin
                if ((op == 7'b0000011 || op == 7'b0100011) && funct3 == 3'b010)
                    state_next = MEMADR;
                else if (op == 7'b0110011 && rtype_ok)
                    state_next = EXECR;
                else if (op == 7'b1100011 && funct3 == 3'b000)
                    state_next = BEQ;
                else
                    state_next = FAULT_ILL;
            end
            // Instr[5] separates sw (0100011) from lw (0000011).
            MEMADR: state_next = Instr[5] ? MEMWR : MEMRD;
            MEMRD: begin
                if (mem_ready)    state_next = MEMWB;
                else if (timeout) state_next = FAULT_TMO;
            end
            MEMWB:  state_next = FETCH;
            MEMWR: begin
                if (mem_ready)    state_next = FETCH;
                else if (timeout) state_next = FAULT_TMO;
            end
            EXECR:     state_next = ALUWB;
            ALUWB:     state_next = FETCH;
            BEQ:       state_next = FETCH;
            FAULT_ILL: state_next = FAULT_ILL;
            FAULT_TMO: state_next = FAULT_TMO;
            default:   state_next = START;
        endcase
    end

    // State and wait counter; the counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= START;
            wait_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (waiting && state_next == state)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= 8'd0;
        end
    end

    // Control decode; anything not driven in a state stays 0.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUsrcA    = 2'b00;
        ALUsrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUctrl    = ALU_ADD;
        ResultSrc  = 2'b00;
        instr_done = 1'b0;
        fault      = 1'b0;
        fault_code = 2'b00;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUsrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            DECODE: begin
                // Branch target PC+immB is computed here into ALUOut.
                ALUsrcA = 2'b01;
                ALUsrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            MEMADR: begin
                ALUsrcA = 2'b10;
                ALUsrcB = 2'b01;
                ImmSrc  = Instr[5] ? 2'b01 : 2'b00;
            end
            MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                mem_req    = 1'b1;
                MemWrite   = 1'b1;
                AdrSrc     = 1'b1;
                instr_done = mem_ready;
            end
            EXECR: begin
                ALUsrcA = 2'b10;
                case (funct3)
                    3'b000:  ALUctrl = Instr[30] ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUctrl = ALU_SLT;
                    3'b110:  ALUctrl = ALU_OR;
                    3'b111:  ALUctrl = ALU_AND;
                    default: ALUctrl = ALU_ADD;
                endcase
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQ: begin
                ALUsrcA    = 2'b10;
                ALUctrl    = ALU_SUB;
                PCWrite    = Zero;
                instr_done = 1'b1;
            end
            FAULT_ILL: begin
                fault      = 1'b1;
                fault_code = 2'b01;
            end
            FAULT_TMO: begin
                fault      = 1'b1;
                fault_code = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares the full control word every cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ALUsrcA, ALUsrcB, ImmSrc, ResultSrc, fault_code;
    logic [2:0]  ALUctrl;
    logic        instr_done, fault;
    logic [3:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A183;
    localparam logic [31:0] I_SW  = 32'h0030A223;
    localparam logic [31:0] I_BEQ = 32'h00208463;

    // Clock generation
    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .ResultSrc(ResultSrc),
        .instr_done(instr_done), .fault(fault), .fault_code(fault_code),
        .state_dbg(state_dbg)
    );

    logic [20:0] outs;
    assign outs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                   ALUsrcA, ALUsrcB, ImmSrc, ALUctrl, ResultSrc,
                   instr_done, fault, fault_code};

    function automatic logic [20:0] ex(input logic req, wr, adr, irw, pcw, rgw,
                                       input logic [1:0] sa, sb, imm,
                                       input logic [2:0] alu,
                                       input logic [1:0] rs,
                                       input logic done, flt,
                                       input logic [1:0] fc);
        return {req, wr, adr, irw, pcw, rgw, sa, sb, imm, alu, rs, done, flt, fc};
    endfunction

    logic [20:0] o_zero, o_fetch_r, o_fetch_w, o_decode, o_memadr_lw, o_memadr_sw;
    logic [20:0] o_memrd, o_memwb, o_memwr, o_memwr_done, o_execr_add, o_aluwb;
    logic [20:0] o_beq_z1, o_beq_z0, o_flt_ill, o_flt_tmo;

    // Step to just after the next rising edge; inputs change and outputs are
    // sampled here, well away from either clock edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; Instr = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (state_dbg !== 4'd0 || outs !== o_zero) begin
            errors++; $display("FAIL reset_state: state=%0d outs=%h exp state=0 outs=%h", state_dbg, outs, o_zero);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (state_dbg !== 4'd0 || outs !== o_zero) begin
            errors++; $display("FAIL reset_release: state=%0d outs=%h exp state=0 outs=%h", state_dbg, outs, o_zero);
        end
    endtask

    task automatic test_add;
        Instr = I_ADD; mem_ready = 1'b1;
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd1 || outs !== o_fetch_r) begin
            errors++; $display("FAIL add_fetch: state=%0d outs=%h exp state=1 outs=%h", state_dbg, outs, o_fetch_r);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd2 || outs !== o_decode) begin
            errors++; $display("FAIL add_decode: state=%0d outs=%h exp state=2 outs=%h", state_dbg, outs, o_decode);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd7 || outs !== o_execr_add) begin
            errors++; $display("FAIL add_execr: state=%0d outs=%h exp state=7 outs=%h", state_dbg, outs, o_execr_add);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd8 || outs !== o_aluwb) begin
            errors++; $display("FAIL add_aluwb: state=%0d outs=%h exp state=8 outs=%h", state_dbg, outs, o_aluwb);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd1 || outs !== o_fetch_r) begin
            errors++; $display("FAIL add_refetch: state=%0d outs=%h exp state=1 outs=%h", state_dbg, outs, o_fetch_r);
        end
    endtask

    task automatic test_rtype_alu;
        logic [31:0] r_instr [4];
        logic [2:0]  r_alu   [4];
        logic [20:0] e;
        r_instr[0] = 32'h402081B3; r_alu[0] = 3'b001;  // sub
        r_instr[1] = 32'h0020A1B3; r_alu[1] = 3'b101;  // slt
        r_instr[2] = 32'h0020E1B3; r_alu[2] = 3'b011;  // or
        r_instr[3] = 32'h0020F1B3; r_alu[3] = 3'b010;  // and
        for (int i = 0; i < 4; i++) begin
            Instr = r_instr[i]; mem_ready = 1'b1;
            tick(); tick(); #1;
            e = ex(0,0,0,0,0,0, 2'b10,2'b00,2'b00, r_alu[i], 2'b00, 0,0,2'b00);
            checks++;
            if (state_dbg !== 4'd7 || outs !== e) begin
                errors++; $display("FAIL rtype_execr[%0d]: state=%0d outs=%h exp state=7 outs=%h", i, state_dbg, outs, e);
            end
            tick(); #1;
            checks++;
            if (state_dbg !== 4'd8 || outs !== o_aluwb) begin
                errors++; $display("FAIL rtype_aluwb[%0d]: state=%0d outs=%h exp state=8 outs=%h", i, state_dbg, outs, o_aluwb);
            end
            tick();
        end
    endtask

    task automatic test_lw_wait;
        int cyc;
        Instr = I_LW; mem_ready = 1'b0; cyc = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_dbg !== 4'd1 || outs !== o_fetch_w) begin
                errors++; $display("FAIL lw_fetch_wait[%0d]: state=%0d outs=%h exp state=1 outs=%h", k, state_dbg, outs, o_fetch_w);
            end
            tick(); cyc++; #1;
        end
        mem_ready = 1'b1; #1;
        checks++;
        if (state_dbg !== 4'd1 || outs !== o_fetch_r) begin
            errors++; $display("FAIL lw_fetch_ready: state=%0d outs=%h exp state=1 outs=%h", state_dbg, outs, o_fetch_r);
        end
        tick(); cyc++; mem_ready = 1'b1; #1;
        checks++;
        if (state_dbg !== 4'd2 || outs !== o_decode) begin
            errors++; $display("FAIL lw_decode: state=%0d outs=%h exp state=2 outs=%h", state_dbg, outs, o_decode);
        end
        tick(); cyc++; #1;
        checks++;
        if (state_dbg !== 4'd3 || outs !== o_memadr_lw) begin
            errors++; $display("FAIL lw_memadr: state=%0d outs=%h exp state=3 outs=%h", state_dbg, outs, o_memadr_lw);
        end
        tick(); cyc++; mem_ready = 1'b0; #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_dbg !== 4'd4 || outs !== o_memrd) begin
                errors++; $display("FAIL lw_memrd_wait[%0d]: state=%0d outs=%h exp state=4 outs=%h", k, state_dbg, outs, o_memrd);
            end
            tick(); cyc++; #1;
        end
        mem_ready = 1'b1; #1;
        checks++;
        if (state_dbg !== 4'd4 || outs !== o_memrd) begin
            errors++; $display("FAIL lw_memrd_ready: state=%0d outs=%h exp state=4 outs=%h", state_dbg, outs, o_memrd);
        end
        tick(); cyc++; #1;
        checks++;
        if (state_dbg !== 4'd5 || outs !== o_memwb || cyc !== 11) begin
            errors++; $display("FAIL lw_memwb: state=%0d outs=%h cyc=%0d exp state=5 outs=%h cyc=11", state_dbg, outs, cyc, o_memwb);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd1) begin
            errors++; $display("FAIL lw_refetch: state=%0d exp 1", state_dbg);
        end
    endtask

    task automatic test_sw;
        Instr = I_SW; mem_ready = 1'b1;
        tick(); tick(); #1;
        checks++;
        if (state_dbg !== 4'd3 || outs !== o_memadr_sw) begin
            errors++; $display("FAIL sw_memadr: state=%0d outs=%h exp state=3 outs=%h", state_dbg, outs, o_memadr_sw);
        end
        tick(); mem_ready = 1'b0; #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (state_dbg !== 4'd6 || outs !== o_memwr) begin
                errors++; $display("FAIL sw_memwr_wait[%0d]: state=%0d outs=%h exp state=6 outs=%h", k, state_dbg, outs, o_memwr);
            end
            tick(); #1;
        end
        mem_ready = 1'b1; #1;
        checks++;
        if (state_dbg !== 4'd6 || outs !== o_memwr_done) begin
            errors++; $display("FAIL sw_memwr_done: state=%0d outs=%h exp state=6 outs=%h", state_dbg, outs, o_memwr_done);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd1 || outs !== o_fetch_r) begin
            errors++; $display("FAIL sw_refetch: state=%0d outs=%h exp state=1 outs=%h", state_dbg, outs, o_fetch_r);
        end
    endtask

    task automatic test_beq;
        Instr = I_BEQ; mem_ready = 1'b1; Zero = 1'b1;
        tick(); tick(); #1;
        checks++;
        if (state_dbg !== 4'd9 || outs !== o_beq_z1) begin
            errors++; $display("FAIL beq_taken: state=%0d outs=%h exp state=9 outs=%h", state_dbg, outs, o_beq_z1);
        end
        tick(); Zero = 1'b0; #1;
        checks++;
        if (state_dbg !== 4'd1) begin
            errors++; $display("FAIL beq_refetch: state=%0d exp 1", state_dbg);
        end
        tick(); tick(); #1;
        checks++;
        if (state_dbg !== 4'd9 || outs !== o_beq_z0) begin
            errors++; $display("FAIL beq_not_taken: state=%0d outs=%h exp state=9 outs=%h", state_dbg, outs, o_beq_z0);
        end
        tick(); #1;
    endtask

    task automatic test_timeout_edge;
        // mem_ready arriving on the last allowed cycle still completes.
        Instr = I_ADD; mem_ready = 1'b0;
        repeat (14) tick();
        #1;
        checks++;
        if (state_dbg !== 4'd1 || outs !== o_fetch_w) begin
            errors++; $display("FAIL tmo_edge_wait: state=%0d outs=%h exp state=1 outs=%h", state_dbg, outs, o_fetch_w);
        end
        mem_ready = 1'b1; #1;
        checks++;
        if (state_dbg !== 4'd1 || outs !== o_fetch_r) begin
            errors++; $display("FAIL tmo_edge_ready: state=%0d outs=%h exp state=1 outs=%h", state_dbg, outs, o_fetch_r);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd2 || fault !== 1'b0) begin
            errors++; $display("FAIL tmo_edge_decode: state=%0d fault=%b exp state=2 fault=0", state_dbg, fault);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_illegal;
        logic [31:0] bad [4];
        bad[0] = 32'h00000013;  // addi: unsupported opcode
        bad[1] = 32'h4020A1B3;  // funct7=0100000 with funct3=010
        bad[2] = 32'h002091B3;  // sll: unsupported funct3
        bad[3] = 32'h00209463;  // bne: unsupported branch
        for (int i = 0; i < 4; i++) begin
            Instr = bad[i]; mem_ready = 1'b1;
            rst_n = 1'b0; #1; rst_n = 1'b1;
            tick(); tick(); tick(); #1;
            checks++;
            if (state_dbg !== 4'd10 || outs !== o_flt_ill) begin
                errors++; $display("FAIL illegal_fault[%0d]: state=%0d outs=%h exp state=10 outs=%h", i, state_dbg, outs, o_flt_ill);
            end
        end
        Instr = I_ADD; tick(); mem_ready = 1'b0; tick(); #1;
        checks++;
        if (state_dbg !== 4'd10 || outs !== o_flt_ill) begin
            errors++; $display("FAIL illegal_sticky: state=%0d outs=%h exp state=10 outs=%h", state_dbg, outs, o_flt_ill);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (state_dbg !== 4'd0 || outs !== o_zero) begin
            errors++; $display("FAIL illegal_reset: state=%0d outs=%h exp state=0 outs=%h", state_dbg, outs, o_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_timeout;
        Instr = I_LW; mem_ready = 1'b1;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick(); tick(); tick(); tick(); mem_ready = 1'b0;
        repeat (14) tick();
        #1;
        checks++;
        if (state_dbg !== 4'd4 || outs !== o_memrd) begin
            errors++; $display("FAIL tmo_last_wait: state=%0d outs=%h exp state=4 outs=%h", state_dbg, outs, o_memrd);
        end
        tick(); #1;
        checks++;
        if (state_dbg !== 4'd11 || outs !== o_flt_tmo) begin
            errors++; $display("FAIL tmo_fault: state=%0d outs=%h exp state=11 outs=%h", state_dbg, outs, o_flt_tmo);
        end
        mem_ready = 1'b1; tick(); tick(); #1;
        checks++;
        if (state_dbg !== 4'd11 || outs !== o_flt_tmo) begin
            errors++; $display("FAIL tmo_sticky: state=%0d outs=%h exp state=11 outs=%h", state_dbg, outs, o_flt_tmo);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (state_dbg !== 4'd0 || outs !== o_zero) begin
            errors++; $display("FAIL tmo_reset: state=%0d outs=%h exp state=0 outs=%h", state_dbg, outs, o_zero);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        o_zero       = '0;
        o_fetch_r    = ex(1,0,0,1,1,0, 2'b00,2'b10,2'b00, 3'b000, 2'b10, 0,0,2'b00);
        o_fetch_w    = ex(1,0,0,0,0,0, 2'b00,2'b10,2'b00, 3'b000, 2'b10, 0,0,2'b00);
        o_decode     = ex(0,0,0,0,0,0, 2'b01,2'b01,2'b10, 3'b000, 2'b00, 0,0,2'b00);
        o_memadr_lw  = ex(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, 2'b00, 0,0,2'b00);
        o_memadr_sw  = ex(0,0,0,0,0,0, 2'b10,2'b01,2'b01, 3'b000, 2'b00, 0,0,2'b00);
        o_memrd      = ex(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,2'b00);
        o_memwb      = ex(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b01, 1,0,2'b00);
        o_memwr      = ex(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,0,2'b00);
        o_memwr_done = ex(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 1,0,2'b00);
        o_execr_add  = ex(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b000, 2'b00, 0,0,2'b00);
        o_aluwb      = ex(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 1,0,2'b00);
        o_beq_z1     = ex(0,0,0,0,1,0, 2'b10,2'b00,2'b00, 3'b001, 2'b00, 1,0,2'b00);
        o_beq_z0     = ex(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b001, 2'b00, 1,0,2'b00);
        o_flt_ill    = ex(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,1,2'b01);
        o_flt_tmo    = ex(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 2'b00, 0,1,2'b10);

        test_reset();
        test_add();
        test_rtype_alu();
        test_lw_wait();
        test_sw();
        test_beq();
        test_timeout_edge();
        test_illegal();
        test_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I subset already decoded by the single-cycle control path: lw, sw, R-type (add/sub/and/or/slt) and beq.
- Drives a shared-memory multi-cycle datapath: PC, IR, OldPC, ALUOut, data register, register file, and one ALU.
- Steps each instruction through fetch/decode/execute/memory/writeback.
- Memory accesses use a req/ready handshake with a timeout.
- Illegal encodings and timeouts trap into a sticky fault state.

Parameters:
- TIMEOUT_CYCLES, 15: maximum number of cycles to wait for mem_ready in one memory state before faulting. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Instr  in  32  IR contents; valid from DECODE onward.
- Zero  in  1  ALU zero flag (the EQ compare for beq).
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  the access is a write.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from the result bus.
- RegWrite  out  1  register file write enable.
- ALUsrcA  out  2  ALU A operand: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUsrcB  out  2  ALU B operand: 00 = rs2, 01 = imm, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B.
- ALUctrl  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT.
- ResultSrc  out  2  result bus: 00 = ALUOut, 01 = data register, 10 = ALU output.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- fault  out  1  sticky fault flag.
- fault_code  out  2  fault cause: 01 = illegal instruction, 10 = memory timeout.

Behaviour:
- Reset: the clock is clk. Reset is asynchronous and active-low (rst_n). Asserting rst_n=0 forces state=START, wait_cnt=0, fault=0, fault_code=00.
- In START every output is 0, including ALUctrl=000.
- Reset mid-operation aborts the instruction immediately; no partial writes occur after the reset edge.
- State register and wait_cnt are the only flops. All other outputs are a combinational decode of state, plus Zero and mem_ready where stated. Any output not listed for a state is 0.
- START: unconditionally -> FETCH on the next cycle.
- FETCH:
  - Drives mem_req=1, AdrSrc=0, ALUsrcA=00, ALUsrcB=10, ALUctrl=ADD, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - On mem_ready -> DECODE.
- DECODE:
  - Drives ALUsrcA=01, ALUsrcB=01, ImmSrc=10, ALUctrl=ADD (branch target into ALUOut).
  - Op 0000011 with funct3=010 -> MEMADR.
  - Op 0100011 with funct3=010 -> MEMADR.
  - Op 0110011 with a legal funct3/funct7 -> EXECR. Legal: funct3 in {000, 010, 110, 111}; Instr[31:25] = 0000000, or 0100000 only when funct3=000.
  - Op 1100011 with funct3=000 -> BEQ.
  - Anything else -> FAULT with code 01.
- MEMADR: drives ALUsrcA=10, ALUsrcB=01, ALUctrl=ADD. ImmSrc=00 for lw, 01 for sw. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Drives mem_req=1, AdrSrc=1.
  - On mem_ready -> MEMWB.
- MEMWB: drives ResultSrc=01, RegWrite=1, instr_done=1. -> FETCH.
- MEMWR:
  - Drives mem_req=1, MemWrite=1, AdrSrc=1; both are held until mem_ready.
  - On mem_ready: instr_done=1 that cycle, -> FETCH.
- EXECR:
  - Drives ALUsrcA=10, ALUsrcB=00.
  - ALUctrl by funct3: 000 gives SUB when Instr[30]=1, else ADD; 010 = SLT; 110 = OR; 111 = AND.
  - -> ALUWB.
- ALUWB: drives ResultSrc=00, RegWrite=1, instr_done=1. -> FETCH.
- BEQ: drives ALUsrcA=10, ALUsrcB=00, ALUctrl=SUB, ResultSrc=00, PCWrite=Zero, instr_done=1. -> FETCH.
- FAULT:
  - fault=1; fault_code holds the value latched on entry. All enables are 0.
  - Exit only by reset.
- Timeout counter:
  - wait_cnt (8 bits) clears on entry to FETCH, MEMRD or MEMWR, and increments each cycle spent in one of those states without mem_ready.
  - Fault condition: wait_cnt == TIMEOUT_CYCLES-1 with mem_ready=0 -> FAULT with code 10, no writes.
  - If mem_ready arrives in that same cycle, it wins: the transfer completes normally and no fault is raised.
- Fixed latencies with zero-wait memory:
  - lw = 5 cycles
  - sw = 4 cycles
  - R-type = 4 cycles
  - beq = 3 cycles
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with mem_ready=1 always -> states START, FETCH, DECODE, EXECR, ALUWB; ALUctrl=000 in EXECR; RegWrite and instr_done high for one cycle in ALUWB.
- sub (0x402081B3), then slt (funct3=010), or (110), and (111) -> ALUctrl in EXECR is 001, 101, 011, 010 respectively.
- lw 0x0000A183 with mem_ready delayed 3 cycles in FETCH and in MEMRD -> mem_req held, IRWrite and PCWrite pulse only on the ready cycle; MEMWB asserts ResultSrc=01 and RegWrite=1; total 11 cycles.
- sw 0x0030A223 -> MEMADR has ImmSrc=01; MEMWR holds MemWrite=1 until ready; RegWrite never asserted.
- beq 0x00208463 with Zero=1 -> PCWrite=1 in BEQ. Same instruction with Zero=0 -> PCWrite=0. instr_done=1 in both cases.
- Op 0010011, or mem_ready held low for TIMEOUT_CYCLES cycles in MEMRD -> fault=1 with fault_code=01 (respectively 10); all enables stay 0 until rst_n pulses low, then state=START.
